// File: rtl/micro_pkg.sv
// Shared constants, key FSM states and the key-vector decoder for the
// microwave keypad front end.
package micro_pkg;

    localparam int KEY_COUNT = 10;
    localparam int DIGIT_W   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } key_state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] idx;
        logic               multi;
    } key_dec_t;

    // Index of the set key plus a flag raised when more than one key is down.
    function automatic key_dec_t key_decode(input logic [KEY_COUNT-1:0] keys);
        key_dec_t           dec;
        logic [DIGIT_W-1:0] ones;
        dec  = '0;
        ones = '0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            if (keys[i]) begin
                dec.idx = DIGIT_W'(i);
                ones    = ones + DIGIT_W'(1);
            end else begin
                ones = ones;
            end
        end
        dec.multi = (ones > DIGIT_W'(1));
        return dec;
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Panel/timer-side signal bundle of the keypad entry stage.
interface keypad_entry_if;
    import micro_pkg::*;

    logic [KEY_COUNT-1:0] teclado;
    logic                 mag_on;
    logic                 limpan;
    logic [DIGIT_W-1:0]   d_data;
    logic                 d_valid;
    logic                 key_err;
    logic                 tick;

    modport master (
        output teclado, mag_on, limpan,
        input  d_data, d_valid, key_err, tick
    );

    modport slave (
        input  teclado, mag_on, limpan,
        output d_data, d_valid, key_err, tick
    );

endinterface

// File: rtl/tick_gen.sv
// Timer count-enable prescaler; runs only while the magnetron is on and
// restarts from zero on every rise of mag_on.
module tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rstn,
    input  logic mag_on,
    output logic tick
);
    localparam int             CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Period counter and registered tick; a partial period is dropped when mag_on falls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (!mag_on) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            tick_r <= (cnt_r == LAST);
            cnt_r  <= (cnt_r == LAST) ? '0 : cnt_r + CW'(1);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: synchronise and debounce the 10 key lines, encode one
// accepted press into a digit strobe, and generate the timer tick.
module keypad_entry
    import micro_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 1000,
    parameter int MAX_DIGITS      = 3
) (
    input logic           clk,
    input logic           rstn,
    keypad_entry_if.slave bus
);
    localparam int                   CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int                   DIG_W    = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [DIG_W-1:0]     DIG_MAX  = DIG_W'(MAX_DIGITS);
    localparam logic [KEY_COUNT-1:0] NO_KEY   = '0;

    logic [KEY_COUNT-1:0] sync1_r, ks_r;
    logic [KEY_COUNT-1:0] cap_r, cap_s;
    key_state_t           state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [DIG_W-1:0]     count_r, count_s;
    logic [DIGIT_W-1:0]   d_data_r, d_data_s;
    logic                 d_valid_r, d_valid_s;
    logic                 key_err_r, key_err_s;
    key_dec_t             dec_s;

    // Two-flop synchroniser: the key lines are asynchronous to clk.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_r <= '0;
            ks_r    <= '0;
        end else begin
            sync1_r <= bus.teclado;
            ks_r    <= sync1_r;
        end
    end

    // Key FSM state, debounce bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IDLE;
            cap_r     <= '0;
            cnt_r     <= '0;
            count_r   <= '0;
            d_data_r  <= '0;
            d_valid_r <= 1'b0;
            key_err_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cap_r     <= cap_s;
            cnt_r     <= cnt_s;
            count_r   <= count_s;
            d_data_r  <= d_data_s;
            d_valid_r <= d_valid_s;
            key_err_r <= key_err_s;
        end
    end

    // Next state: debounce a press, accept or flag it, then debounce the release.
    always_comb begin
        state_s   = state_r;
        cap_s     = cap_r;
        cnt_s     = cnt_r;
        count_s   = count_r;
        d_data_s  = d_data_r;
        d_valid_s = 1'b0;
        key_err_s = 1'b0;
        dec_s     = key_decode(cap_r);

        case (state_r)
            IDLE: begin
                if (ks_r != NO_KEY) begin
                    cap_s   = ks_r;
                    cnt_s   = CNT_ONE;
                    state_s = DEBOUNCE;
                end else begin
                    state_s = IDLE;
                end
            end
            DEBOUNCE: begin
                if (ks_r == NO_KEY) begin
                    state_s = IDLE;
                end else if (ks_r != cap_r) begin
                    cap_s = ks_r;
                    cnt_s = CNT_ONE;
                end else if (cnt_r == CNT_DONE) begin
                    state_s = HELD;
                    if (dec_s.multi) begin
                        key_err_s = 1'b1;
                    end else if (!bus.mag_on && (count_r < DIG_MAX)) begin
                        d_data_s  = dec_s.idx;
                        d_valid_s = 1'b1;
                        count_s   = count_r + DIG_W'(1);
                    end else begin
                        // Single key while cooking or with entry full: dropped silently.
                        d_valid_s = 1'b0;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            HELD: begin
                if (ks_r == NO_KEY) begin
                    cnt_s   = CNT_ONE;
                    state_s = RELEASE;
                end else begin
                    state_s = HELD;
                end
            end
            RELEASE: begin
                if (ks_r != NO_KEY) begin
                    state_s = HELD;
                end else if (cnt_r == CNT_DONE) begin
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // A clear overrides an accept landing in the same cycle.
        if (!bus.limpan) begin
            count_s = '0;
        end else begin
            count_s = count_s;
        end
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rstn   (rstn),
        .mag_on (bus.mag_on),
        .tick   (bus.tick)
    );

    assign bus.d_data  = d_data_r;
    assign bus.d_valid = d_valid_r;
    assign bus.key_err = key_err_r;

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry against a run-length reference model.
module tb_keypad_entry;
    import micro_pkg::*;

    localparam int DEB  = 4;
    localparam int TDIV = 10;
    localparam int MAXD = 3;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    keypad_entry_if bus ();

    keypad_entry #(
        .DEBOUNCE_CYCLES (DEB),
        .TICK_DIV        (TDIV),
        .MAX_DIGITS      (MAXD)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a press is accepted when the synchronised pattern has
    // been the same nonzero value for DEB+1 samples since the last full release
    // (DEB+1 zero samples); ticks come every TDIV cycles of continuous mag_on.
    logic [9:0] m_p1, m_ks, m_prev;
    int         m_run, m_digits, m_on;
    logic       m_armed;
    logic [3:0] exp_data;
    logic       exp_valid, exp_err, exp_tick;

    int         n_run, n_digits, n_on, n_idx;
    logic       n_fire, n_armed, n_valid, n_err, n_tick;
    logic [3:0] n_data;

    always_comb begin
        n_run = (m_ks == m_prev) ? m_run + 1 : 1;
        if (n_run > 1000) n_run = 1000;
        n_fire  = m_armed && (m_ks != 10'd0) && (n_run == DEB + 1);
        n_armed = m_armed;
        if (n_fire) n_armed = 1'b0;
        else if (!m_armed && (m_ks == 10'd0) && (n_run == DEB + 1)) n_armed = 1'b1;
        n_idx = 0;
        for (int i = 0; i < 10; i++) if (m_ks[i]) n_idx = i;
        n_valid  = n_fire && ($countones(m_ks) == 1) && !bus.mag_on && (m_digits < MAXD);
        n_err    = n_fire && ($countones(m_ks) > 1);
        n_data   = n_valid ? 4'(n_idx) : exp_data;
        n_digits = !bus.limpan ? 0 : m_digits + (n_valid ? 1 : 0);
        n_on     = bus.mag_on ? m_on + 1 : 0;
        n_tick   = bus.mag_on && ((n_on % TDIV) == 0);
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_p1 <= '0; m_ks <= '0; m_prev <= '0;
            m_run <= 0; m_digits <= 0; m_on <= 0; m_armed <= 1'b1;
            exp_data <= '0; exp_valid <= 1'b0; exp_err <= 1'b0; exp_tick <= 1'b0;
        end else begin
            m_p1 <= bus.teclado; m_ks <= m_p1; m_prev <= m_ks;
            m_run <= n_run; m_digits <= n_digits; m_on <= n_on; m_armed <= n_armed;
            exp_data <= n_data; exp_valid <= n_valid; exp_err <= n_err; exp_tick <= n_tick;
        end
    end

    task automatic test_reset();
        rstn = 1'b0;
        bus.teclado = '0; bus.mag_on = 1'b0; bus.limpan = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.d_valid, bus.key_err, bus.tick, bus.d_data} !== 7'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0000000", {bus.d_valid, bus.key_err, bus.tick, bus.d_data});
        end
        rstn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.d_valid, bus.key_err, bus.tick, bus.d_data} !== 7'd0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%b want=0000000", c, {bus.d_valid, bus.key_err, bus.tick, bus.d_data});
            end
        end
    endtask

    task automatic test_single_key();
        int nval = 0, first = -1;
        for (int c = 0; c < 30; c++) begin
            bus.teclado = (c < 20) ? 10'h020 : 10'h000;
            @(negedge clk);
            checks++;
            if ({bus.d_valid, bus.key_err, bus.tick, bus.d_data} !== {exp_valid, exp_err, exp_tick, exp_data}) begin
                failures++;
                $display("FAIL single_model cyc=%0d got=%b want=%b", c, {bus.d_valid, bus.key_err, bus.tick, bus.d_data}, {exp_valid, exp_err, exp_tick, exp_data});
            end
            if (bus.d_valid) begin
                nval++;
                if (first < 0) first = c;
                checks++;
                if (bus.d_data !== 4'd5) begin
                    failures++;
                    $display("FAIL single_data got=%0d want=5", bus.d_data);
                end
            end
        end
        checks++;
        if (nval !== 1) begin failures++; $display("FAIL single_count got=%0d want=1", nval); end
        checks++;
        if (first !== 6) begin failures++; $display("FAIL single_latency got=%0d want=6", first); end
    endtask

    task automatic test_bounce();
        int nval = 0, nerr = 0;
        for (int c = 0; c < 35; c++) begin
            if (c < 10) bus.teclado = (((c / 2) % 2) == 0) ? 10'h008 : 10'h000;
            else        bus.teclado = (c < 25) ? 10'h008 : 10'h000;
            @(negedge clk);
            checks++;
            if ({bus.d_valid, bus.key_err, bus.tick, bus.d_data} !== {exp_valid, exp_err, exp_tick, exp_data}) begin
                failures++;
                $display("FAIL bounce_model cyc=%0d got=%b want=%b", c, {bus.d_valid, bus.key_err, bus.tick, bus.d_data}, {exp_valid, exp_err, exp_tick, exp_data});
            end
            if (bus.key_err) nerr++;
            if (bus.d_valid) begin
                nval++;
                checks++;
                if (bus.d_data !== 4'd3) begin failures++; $display("FAIL bounce_data got=%0d want=3", bus.d_data); end
            end
        end
        checks++;
        if (nval !== 1) begin failures++; $display("FAIL bounce_count got=%0d want=1", nval); end
        checks++;
        if (nerr !== 0) begin failures++; $display("FAIL bounce_err got=%0d want=0", nerr); end
    endtask

    task automatic test_multi_key();
        int nval = 0, nerr = 0;
        for (int c = 0; c < 27; c++) begin
            bus.teclado = (c < 15) ? 10'h009 : 10'h000;
            @(negedge clk);
            checks++;
            if ({bus.d_valid, bus.key_err, bus.tick, bus.d_data} !== {exp_valid, exp_err, exp_tick, exp_data}) begin
                failures++;
                $display("FAIL multi_model cyc=%0d got=%b want=%b", c, {bus.d_valid, bus.key_err, bus.tick, bus.d_data}, {exp_valid, exp_err, exp_tick, exp_data});
            end
            if (bus.key_err) nerr++;
            if (bus.d_valid) nval++;
        end
        checks++;
        if (nerr !== 1) begin failures++; $display("FAIL multi_err got=%0d want=1", nerr); end
        checks++;
        if (nval !== 0) begin failures++; $display("FAIL multi_valid got=%0d want=0", nval); end
        checks++;
        if (bus.d_data !== 4'd3) begin failures++; $display("FAIL multi_data_kept got=%0d want=3", bus.d_data); end
    endtask

    task automatic test_digit_limit();
        int keys[5] = '{1, 2, 3, 4, 7};
        int want[4] = '{1, 2, 3, 7};
        int got[$];
        int hold, rel;
        for (int k = 0; k < 5; k++) begin
            if (k == 0 || k == 4) begin
                bus.limpan = 1'b0;
                @(negedge clk);
                checks++;
                if ({bus.d_valid, bus.key_err, bus.tick, bus.d_data} !== {exp_valid, exp_err, exp_tick, exp_data}) begin
                    failures++;
                    $display("FAIL limit_clear_model got=%b want=%b", {bus.d_valid, bus.key_err, bus.tick, bus.d_data}, {exp_valid, exp_err, exp_tick, exp_data});
                end
                bus.limpan = 1'b1;
            end
            hold = $urandom_range(10, 6);
            rel  = $urandom_range(9, 6);
            for (int c = 0; c < hold + rel; c++) begin
                bus.teclado = '0;
                if (c < hold) bus.teclado[keys[k]] = 1'b1;
                @(negedge clk);
                checks++;
                if ({bus.d_valid, bus.key_err, bus.tick, bus.d_data} !== {exp_valid, exp_err, exp_tick, exp_data}) begin
                    failures++;
                    $display("FAIL limit_model key=%0d cyc=%0d got=%b want=%b", keys[k], c, {bus.d_valid, bus.key_err, bus.tick, bus.d_data}, {exp_valid, exp_err, exp_tick, exp_data});
                end
                if (bus.d_valid) got.push_back(int'(bus.d_data));
            end
        end
        checks++;
        if (got.size() !== 4) begin
            failures++;
            $display("FAIL limit_strobes got=%0d want=4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== want[i]) begin failures++; $display("FAIL limit_digit idx=%0d got=%0d want=%0d", i, got[i], want[i]); end
            end
        end
    endtask

    task automatic test_mag_tick();
        int want[4] = '{9, 19, 29, 49};
        int ticks[$];
        int nval = 0;
        for (int c = 0; c < 55; c++) begin
            bus.mag_on  = !(c >= 35 && c < 40);
            bus.teclado = (c >= 3 && c < 20) ? 10'h200 : 10'h000;
            @(negedge clk);
            checks++;
            if ({bus.d_valid, bus.key_err, bus.tick, bus.d_data} !== {exp_valid, exp_err, exp_tick, exp_data}) begin
                failures++;
                $display("FAIL tick_model cyc=%0d got=%b want=%b", c, {bus.d_valid, bus.key_err, bus.tick, bus.d_data}, {exp_valid, exp_err, exp_tick, exp_data});
            end
            if (bus.tick) ticks.push_back(c);
            if (bus.d_valid) nval++;
        end
        bus.mag_on = 1'b0;
        checks++;
        if (nval !== 0) begin failures++; $display("FAIL tick_blocked_entry got=%0d want=0", nval); end
        checks++;
        if (ticks.size() !== 4) begin
            failures++;
            $display("FAIL tick_count got=%0d want=4", ticks.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ticks[i] !== want[i]) begin failures++; $display("FAIL tick_pos idx=%0d got=%0d want=%0d", i, ticks[i], want[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        bus.teclado = 10'h004;
        repeat (4) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({bus.d_valid, bus.key_err, bus.tick, bus.d_data} !== 7'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs got=%b want=0000000", {bus.d_valid, bus.key_err, bus.tick, bus.d_data});
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.teclado = (c < 12) ? 10'h004 : 10'h000;
            @(negedge clk);
            checks++;
            if ({bus.d_valid, bus.key_err, bus.tick, bus.d_data} !== {exp_valid, exp_err, exp_tick, exp_data}) begin
                failures++;
                $display("FAIL reset_mid_model cyc=%0d got=%b want=%b", c, {bus.d_valid, bus.key_err, bus.tick, bus.d_data}, {exp_valid, exp_err, exp_tick, exp_data});
            end
            if (bus.d_valid && first < 0) begin
                first = c;
                checks++;
                if (bus.d_data !== 4'd2) begin failures++; $display("FAIL reset_mid_data got=%0d want=2", bus.d_data); end
            end
        end
        checks++;
        if (first !== 6) begin failures++; $display("FAIL reset_mid_latency got=%0d want=6", first); end
    endtask

    task automatic test_random();
        int         seg = 0;
        int         r;
        logic [9:0] pat = '0;
        for (int c = 0; c < 600; c++) begin
            if (seg == 0) begin
                r   = $urandom_range(9, 0);
                pat = '0;
                if (r >= 3) pat[$urandom_range(9, 0)] = 1'b1;
                if (r >= 8) pat[$urandom_range(9, 0)] = 1'b1;
                seg = $urandom_range(12, 1);
            end
            seg--;
            bus.teclado = pat;
            if ($urandom_range(39, 0) == 0) bus.mag_on = ~bus.mag_on;
            bus.limpan = ($urandom_range(24, 0) != 0);
            @(negedge clk);
            checks++;
            if ({bus.d_valid, bus.key_err, bus.tick, bus.d_data} !== {exp_valid, exp_err, exp_tick, exp_data}) begin
                failures++;
                $display("FAIL random_model cyc=%0d got=%b want=%b", c, {bus.d_valid, bus.key_err, bus.tick, bus.d_data}, {exp_valid, exp_err, exp_tick, exp_data});
            end
        end
        bus.teclado = '0; bus.mag_on = 1'b0; bus.limpan = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_key();
        test_bounce();
        test_multi_key();
        test_digit_limit();
        test_mag_tick();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Front-end stage between the raw 10-key panel and the BCD countdown timer.
- Synchronises and debounces `teclado`, then encodes one accepted key press into a 4-bit digit with a single-cycle load strobe for the timer.
- Blocks entry while the magnetron runs and limits the number of entered digits.
- Generates the timer's one-per-period count-enable tick, which runs only while the magnetron is on.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised cycles needed to accept a press or a release (>=2).
- TICK_DIV, 1000: clk cycles per timer tick (>=2).
- MAX_DIGITS, 3: digits accepted before entry saturates.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- teclado  input  10  raw key lines, bit i = key i, active-high, asynchronous to clk.
- mag_on  input  1  magnetron running (from magnetron stage).
- limpan  input  1  active-low clear, sampled synchronously; clears digit count.
- d_data  output  4  last accepted digit, binary 0-9.
- d_valid  output  1  one-cycle load strobe to timer (Cin).
- key_err  output  1  one-cycle pulse on debounced multi-key press.
- tick  output  1  one-cycle timer count enable.

Behaviour:
- Reset is asynchronous, active-low. Reset forces all of the following to 0:
  - state = IDLE, synchroniser flops, debounce counter, digit count, tick counter;
  - d_data, d_valid, key_err, tick.
- Input path: 2-flop synchroniser on all 10 bits; the FSM sees the synchronised value `ks`.
- Key FSM (registered outputs):
  - IDLE: if ks != 0, latch `cap` = ks, set cnt = 1, go to DEBOUNCE.
  - DEBOUNCE:
    - ks == cap: cnt increments.
    - ks == 0: return to IDLE.
    - ks differs and is nonzero: relatch `cap`, set cnt = 1.
    - When cnt reaches DEBOUNCE_CYCLES, evaluate acceptance (below), then go to HELD.
  - Acceptance:
    - `cap` has exactly one bit set, mag_on == 0 and count < MAX_DIGITS: d_data = index of set bit, d_valid = 1 for one cycle, count increments.
    - `cap` has more than one bit set: key_err = 1 for one cycle; d_data and count unchanged.
    - Otherwise (single key, but mag_on == 1 or count saturated): press silently ignored.
  - HELD: if ks == 0, set cnt = 1 and go to RELEASE; otherwise stay.
  - RELEASE:
    - ks == 0: cnt increments; at DEBOUNCE_CYCLES go to IDLE.
    - ks != 0: go back to HELD. No new strobe until a full release has been debounced.
- Latency: a pattern stable at the pin from edge 0 produces d_valid high in the cycle after edge DEBOUNCE_CYCLES+2.
- d_valid and key_err are never high in the same cycle; each is exactly one cycle wide.
- Count clear: limpan low at an edge sets count = 0. The FSM and d_data are unaffected. If a clear and an accept happen in the same cycle, clear wins and count = 0.
- Tick generator:
  - While mag_on == 0: the counter is held at 0 and tick = 0.
  - While mag_on == 1: the counter runs 0..TICK_DIV-1 and wraps.
  - tick = 1 in the cycle the counter equals TICK_DIV-1. The first tick therefore comes exactly TICK_DIV cycles after mag_on rises.
  - mag_on falling mid-period discards the partial period.
- Reset mid-operation: outputs go to 0 immediately. A key still held after reset release is treated as a fresh press from IDLE.

Decomposition:
- Shared package `micro_pkg` holds:
  - constants KEY_COUNT = 10 and DIGIT_W = 4;
  - the key FSM state enum (IDLE, DEBOUNCE, HELD, RELEASE);
  - a one-hot-to-index function returning the index plus a multi-bit flag.
- One natural sub-module, `tick_gen`, is the TICK_DIV prescaler gated by mag_on. The FSM and the synchroniser stay in keypad_entry.

Test Plan:
- All scenarios use DEBOUNCE_CYCLES=4, TICK_DIV=10, MAX_DIGITS=3.
1. teclado=0x020 held 20 cycles, then 0 for 10 cycles -> exactly one d_valid, 7 cycles after the press, with d_data=5; no further strobe.
2. Bit 3 toggling every 2 cycles for 10 cycles, then stable high -> exactly one d_valid, d_data=3; no key_err.
3. teclado=0x009 held -> one key_err pulse, no d_valid, d_data keeps its previous value.
4. Presses 1, 2, 3, 4 (each released) -> d_valid with d_data = 1, 2, 3; the fourth press is ignored. Then limpan low for 1 cycle and press 7 -> d_valid, d_data=7.
5. mag_on rises -> tick 10, 20 and 30 cycles after the rise. Key 9 pressed meanwhile -> no d_valid. mag_on low at cycle 35, then high again -> next tick 10 cycles after the new rise.
6. rstn pulsed low during DEBOUNCE with key 2 held -> all outputs 0 asynchronously. After release with key 2 still held -> d_valid, d_data=2, after the full 7-cycle latency.
